// File: rtl/step_move_sequencer.sv
// Single-move STEP/DIR sequencer for an A4988 driver: latches one command, waits the
// DIR/MS setup time, issues exactly n_steps full-width STEP pulses, then pulses done.
module step_move_sequencer #(
  parameter int CNT_W         = 16,
  parameter int PER_W         = 24,
  parameter int STEP_HIGH_CYC = 100,
  parameter int DIR_SETUP_CYC = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir_in,
  input  logic [2:0]       ms_sel,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic             STEP,
  output logic             DIR,
  output logic [2:0]       MS,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PER_W-1:0] MIN_PER      = PER_W'(2 * STEP_HIGH_CYC);
  localparam logic [PER_W-1:0] HI_RELOAD    = PER_W'(STEP_HIGH_CYC - 1);
  localparam logic [PER_W-1:0] SETUP_RELOAD = PER_W'(DIR_SETUP_CYC - 1);
  localparam logic [PER_W-1:0] LO_OFFSET    = PER_W'(STEP_HIGH_CYC + 1);

  logic [2:0]       state;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] lo_reload;
  logic             abort_pend;
  logic [PER_W-1:0] eff_per;
  logic [PER_W-1:0] lo_next;

  function automatic logic [2:0] ms_map(input logic [2:0] sel);
    case (sel)
      3'b000:  ms_map = 3'b000;
      3'b001:  ms_map = 3'b100;
      3'b010:  ms_map = 3'b010;
      3'b011:  ms_map = 3'b110;
      3'b100:  ms_map = 3'b111;
      default: ms_map = 3'b000;
    endcase
  endfunction

  // Clamping the period keeps the LO phase at least as long as the HI phase.
  assign eff_per = (period < MIN_PER) ? MIN_PER : period;
  assign lo_next = eff_per - LO_OFFSET;

  // NOTE: all state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lo_reload  <= '0;
      abort_pend <= 1'b0;
      STEP       <= 1'b0;
      DIR        <= 1'b0;
      MS         <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            DIR        <= dir_in;
            MS         <= ms_map(ms_sel);
            steps_left <= n_steps;
            lo_reload  <= lo_next;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (n_steps == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SETUP;
              busy  <= 1'b1;
              cnt   <= SETUP_RELOAD;
            end
          end
        end
        S_SETUP: begin
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            state <= S_HI;
            STEP  <= 1'b1;
            cnt   <= HI_RELOAD;
          end else begin
            cnt <= cnt - PER_W'(1);
          end
        end
        S_HI: begin
          // An abort during HI is remembered so the pulse still finishes at full width.
          if (abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            STEP       <= 1'b0;
            steps_left <= steps_left - CNT_W'(1);
            if (abort || abort_pend) begin
              state   <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              aborted <= 1'b1;
            end else begin
              state <= S_LO;
              cnt   <= lo_reload;
            end
          end else begin
            cnt <= cnt - PER_W'(1);
          end
        end
        S_LO: begin
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            if (steps_left != '0) begin
              state <= S_HI;
              STEP  <= 1'b1;
              cnt   <= HI_RELOAD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - PER_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_move_sequencer.sv
// Scoreboard bench for step_move_sequencer: expected STEP rises and done events are queued
// when a command is issued and matched by a monitor sampling on the falling clock edge.
module tb_step_move_sequencer;

  localparam int CNT_W = 16;
  localparam int PER_W = 24;
  localparam int SH    = 4;
  localparam int DS    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dir_in;
  logic [2:0]       ms_sel;
  logic [CNT_W-1:0] n_steps;
  logic [PER_W-1:0] period;
  logic             abort;
  logic             STEP;
  logic             DIR;
  logic [2:0]       MS;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;

  step_move_sequencer #(
    .CNT_W(CNT_W), .PER_W(PER_W), .STEP_HIGH_CYC(SH), .DIR_SETUP_CYC(DS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .ms_sel(ms_sel),
    .n_steps(n_steps), .period(period), .abort(abort), .STEP(STEP), .DIR(DIR),
    .MS(MS), .busy(busy), .done(done), .aborted(aborted), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int sl; } rise_t;
  typedef struct { int k; logic ab; int sl; } done_t;

  rise_t rise_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int e0 = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: cycle k of a move is the interval sampled by the k-th edge after the accept edge.
  logic prev_step = 1'b0;
  int   last_rise = 0;
  always @(negedge clk) begin
    int    k;
    rise_t r;
    done_t d;
    k = edge_cnt - e0 + 1;
    if (!rst) begin
      if (STEP && !prev_step) begin
        last_rise = k;
        if (rise_q.size() == 0) check("unexpected_step_rise", rise_q.size(), 1);
        else begin
          r = rise_q.pop_front();
          check("step_rise_cycle", k, r.k);
          check("steps_left_at_rise", steps_left, r.sl);
        end
      end
      if (!STEP && prev_step) check("step_high_width", k - last_rise, SH);
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", done_q.size(), 1);
        else begin
          d = done_q.pop_front();
          check("done_cycle", k, d.k);
          check("done_aborted", aborted, d.ab);
          check("done_steps_left", steps_left, d.sl);
          check("done_busy_low", busy, 0);
          check("done_step_low", STEP, 0);
        end
      end
    end
    prev_step = STEP;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_cycle(input int k);
    for (int i = 0; i < 1000 && (edge_cnt - e0 + 1) < k; i++) tick();
  endtask

  task automatic push_move(input int n, input int eff);
    for (int i = 0; i < n; i++) rise_q.push_back('{k: DS + 1 + i * eff, sl: n - i});
    done_q.push_back('{k: (n == 0) ? 1 : DS + 1 + n * eff, ab: 1'b0, sl: 0});
  endtask

  task automatic issue(input int n, input int per, input logic d, input logic [2:0] ms,
                       input logic ab);
    n_steps = n[CNT_W-1:0];
    period  = per[PER_W-1:0];
    dir_in  = d;
    ms_sel  = ms;
    abort   = ab;
    start   = 1'b1;
    e0      = edge_cnt + 1;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (rise_q.size() + done_q.size()) != 0; i++) tick();
    check("queue_drained", rise_q.size() + done_q.size(), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir_in = 1'b0; ms_sel = 3'b000;
    n_steps = '0; period = '0; abort = 1'b0;
    #12;
    check("rst_step", STEP, 0);
    check("rst_dir", DIR, 0);
    check("rst_ms", MS, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_steps_left", steps_left, 0);
    tick();
    rst = 1'b0;
    tick(); tick();

    // Normal three-step move, DIR/MS latched at accept and held afterwards
    push_move(3, 10);
    issue(3, 10, 1'b1, 3'b010, 1'b0);
    check("t1_dir", DIR, 1);
    check("t1_ms", MS, 3'b010);
    check("t1_busy", busy, 1);
    wait_done(200);
    check("t1_dir_held", DIR, 1);
    check("t1_ms_held", MS, 3'b010);

    // Short period clamps to 2*SH; abort alongside start is ignored; period change mid-move ignored
    push_move(2, 2 * SH);
    issue(2, 5, 1'b0, 3'b100, 1'b1);
    check("t2_ms_sixteenth", MS, 3'b111);
    check("t2_dir", DIR, 0);
    period = 24'd100;
    wait_done(200);

    // Zero-step command goes straight to done
    push_move(0, 10);
    issue(0, 10, 1'b1, 3'b001, 1'b0);
    check("t3_busy_low", busy, 0);
    check("t3_step_low", STEP, 0);
    wait_done(20);

    // Abort during HI of the second pulse
    rise_q.push_back('{k: 4, sl: 5});
    rise_q.push_back('{k: 14, sl: 4});
    done_q.push_back('{k: 18, ab: 1'b1, sl: 3});
    issue(5, 10, 1'b1, 3'b011, 1'b0);
    check("t4_ms_eighth", MS, 3'b110);
    at_cycle(15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(200);
    tick(); tick();
    check("t4_aborted_held", aborted, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();
    check("t4_idle_abort_busy", busy, 0);
    check("t4_idle_abort_aborted", aborted, 1);

    // Abort during LO ends the move on the next edge
    rise_q.push_back('{k: 4, sl: 4});
    done_q.push_back('{k: 11, ab: 1'b1, sl: 3});
    issue(4, 10, 1'b0, 3'b001, 1'b0);
    check("t4b_aborted_cleared", aborted, 0);
    check("t4b_ms_half", MS, 3'b100);
    at_cycle(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(200);

    // Reserved ms_sel maps to full step; start during a move is ignored
    push_move(3, 8);
    issue(3, 8, 1'b1, 3'b101, 1'b0);
    check("t5_ms_reserved", MS, 3'b000);
    at_cycle(5);
    n_steps = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300);
    tick(); tick();
    check("t5_idle_after", busy, 0);

    // Asynchronous reset in the middle of a STEP pulse
    push_move(5, 10);
    issue(5, 10, 1'b1, 3'b100, 1'b0);
    at_cycle(15);
    check("t6_step_before_rst", STEP, 1);
    rst = 1'b1;
    #1;
    check("t6_step", STEP, 0);
    check("t6_busy", busy, 0);
    check("t6_ms", MS, 0);
    check("t6_dir", DIR, 0);
    check("t6_steps_left", steps_left, 0);
    rise_q.delete();
    done_q.delete();
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check("t6_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
